// File: rtl/digit_entry_pkg.sv
// rtl/digit_entry_pkg.sv - shared widths, digit type and entry state encoding
package digit_entry_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } entry_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronise, debounce and rising-edge detect one raw button
module button_debounce
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic             armed;
  logic [1:0]       warm;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, debounce counter, edge detect. A button still held
  // through reset stays disarmed until it has been seen released, so it has to
  // be pressed again before it produces an event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      warm    <= 2'b00;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      warm    <= {warm[0], 1'b1};
      if (warm[1] && !sync2) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      level_q <= level;
      press   <= level & ~level_q & armed;
    end
  end

endmodule

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - three-digit operand entry shift register; DIGIT_ENTRY_ROLLOVER_EN lets enter in FULL shift out hex2
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGIT       = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit_in,
  input  logic       enter_btn,
  input  logic       backspace_btn,
  input  logic       clear_btn,
  output logic [3:0] hex0char,
  output logic [3:0] hex1char,
  output logic [3:0] hex2char,
  output logic [1:0] digit_count,
  output logic       accept,
  output logic       reject
);

  localparam digit_t MAX_D = digit_t'(MAX_DIGIT);

  logic enter_ev;
  logic back_ev;
  logic clear_ev;

  entry_state_t state, state_n;
  digit_t       d0, d1, d2, d0_n, d1_n, d2_n;
  logic [1:0]   count, count_n;
  logic         acc_n, rej_n;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset_n(reset_n), .raw(enter_btn), .press(enter_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .reset_n(reset_n), .raw(backspace_btn), .press(back_ev)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset_n(reset_n), .raw(clear_btn), .press(clear_ev)
  );

  // State, digit and pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= EMPTY;
      d0     <= '0;
      d1     <= '0;
      d2     <= '0;
      count  <= 2'd0;
      accept <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_n;
      d0     <= d0_n;
      d1     <= d1_n;
      d2     <= d2_n;
      count  <= count_n;
      accept <= acc_n;
      reject <= rej_n;
    end
  end

  // Next-state: clear beats backspace beats enter; losers are dropped silently.
  always_comb begin
    state_n = state;
    d0_n    = d0;
    d1_n    = d1;
    d2_n    = d2;
    count_n = count;
    acc_n   = 1'b0;
    rej_n   = 1'b0;
    if (clear_ev) begin
      state_n = EMPTY;
      d0_n    = '0;
      d1_n    = '0;
      d2_n    = '0;
      count_n = 2'd0;
      acc_n   = 1'b1;
    end else if (back_ev) begin
      if (state == EMPTY) begin
        rej_n = 1'b1;
      end else begin
        d0_n    = d1;
        d1_n    = d2;
        d2_n    = '0;
        count_n = count - 2'd1;
        state_n = (count == 2'd1) ? EMPTY : PARTIAL;
        acc_n   = 1'b1;
      end
    end else if (enter_ev) begin
      if (digit_in > MAX_D) begin
        rej_n = 1'b1;
      end else if (state == FULL) begin
`ifdef DIGIT_ENTRY_ROLLOVER_EN
        d2_n  = d1;
        d1_n  = d0;
        d0_n  = digit_in;
        acc_n = 1'b1;
`else
        rej_n = 1'b1;
`endif
      end else begin
        d2_n    = d1;
        d1_n    = d0;
        d0_n    = digit_in;
        count_n = count + 2'd1;
        state_n = (count == 2'd2) ? FULL : PARTIAL;
        acc_n   = 1'b1;
      end
    end
  end

  assign hex0char    = d0;
  assign hex1char    = d1;
  assign hex2char    = d2;
  assign digit_count = count;

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - directed and random self-checking bench for digit_entry
module tb_digit_entry;

  localparam int D    = 16;
  localparam int MAXD = 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter_btn = 1'b0;
  logic       backspace_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [3:0] hex0char, hex1char, hex2char;
  logic [1:0] digit_count;
  logic       accept, reject;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int ent[$];

  digit_entry #(.DEBOUNCE_CYCLES(D), .MAX_DIGIT(MAXD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .digit_in(digit_in),
    .enter_btn(enter_btn),
    .backspace_btn(backspace_btn),
    .clear_btn(clear_btn),
    .hex0char(hex0char),
    .hex1char(hex1char),
    .hex2char(hex2char),
    .digit_count(digit_count),
    .accept(accept),
    .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered digits in order, newest last; hex0 is the newest.
  function automatic int exp_hex(input int n);
    if (n < ent.size()) return ent[ent.size()-1-n];
    return 0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " hex0"}, hex0char, exp_hex(0));
    chk({tag, " hex1"}, hex1char, exp_hex(1));
    chk({tag, " hex2"}, hex2char, exp_hex(2));
    chk({tag, " count"}, digit_count, ent.size());
  endtask

  task automatic model_event(input bit e, input bit b, input bit c, input int d,
                             output bit acc, output bit rej);
    acc = 0;
    rej = 0;
    if (c) begin
      ent.delete();
      acc = 1;
    end else if (b) begin
      if (ent.size() == 0) rej = 1;
      else begin
        void'(ent.pop_back());
        acc = 1;
      end
    end else if (e) begin
      if (d > MAXD) rej = 1;
      else if (ent.size() == 3) begin
`ifdef DIGIT_ENTRY_ROLLOVER_EN
        void'(ent.pop_front());
        ent.push_back(d);
        acc = 1;
`else
        rej = 1;
`endif
      end else begin
        ent.push_back(d);
        acc = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_btns(input string tag);
    bit seen = 0;
    @(negedge clk);
    enter_btn = 0;
    backspace_btn = 0;
    clear_btn = 0;
    for (int k = 0; k < D + 8; k++) begin
      @(posedge clk);
      #1;
      if (accept || reject) seen = 1;
    end
    chk({tag, " release quiet"}, seen, 0);
  endtask

  task automatic press(input string tag, input bit e, input bit b, input bit c, input logic [3:0] d);
    bit acc, rej;
    bit early = 0;
    model_event(e, b, c, int'(d), acc, rej);
    @(negedge clk);
    digit_in = d;
    enter_btn = e;
    backspace_btn = b;
    clear_btn = c;
    for (int k = 0; k <= D + 4; k++) begin
      @(posedge clk);
      #1;
      if (k < D + 4 && (accept || reject)) early = 1;
    end
    chk({tag, " early"}, early, 0);
    chk({tag, " accept"}, accept, acc);
    chk({tag, " reject"}, reject, rej);
    check_state(tag);
    @(posedge clk);
    #1;
    chk({tag, " one-cycle"}, accept | reject, 0);
    release_btns(tag);
  endtask

  initial begin
    bit seen;
    bit e, b, c;
    int r;

    reset_n = 0;
    idle(3);
    ent.delete();
    chk("reset accept", accept, 0);
    chk("reset reject", reject, 0);
    check_state("reset");
    @(negedge clk);
    reset_n = 1;
    idle(5);

    press("enter4", 1, 0, 0, 4'd4);
    press("enter7", 1, 0, 0, 4'd7);
    press("enter2", 1, 0, 0, 4'd2);

    press("clear1", 0, 0, 1, 4'd0);

    seen = 0;
    @(negedge clk);
    digit_in = 4'd1;
    for (int t = 0; t < 14; t++) begin
      enter_btn = (t % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        if (accept || reject) seen = 1;
      end
      @(negedge clk);
    end
    enter_btn = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (accept || reject) seen = 1;
    end
    chk("bounce quiet", seen, 0);
    press("bounce hold", 1, 0, 0, 4'd1);

    press("enterA", 1, 0, 0, 4'hA);
    press("enter2b", 1, 0, 0, 4'd2);
    press("enter3", 1, 0, 0, 4'd3);
    press("full enter5", 1, 0, 0, 4'd5);

    press("clear2", 0, 0, 1, 4'd0);
    press("re1", 1, 0, 0, 4'd1);
    press("re2", 1, 0, 0, 4'd2);
    press("re3", 1, 0, 0, 4'd3);
    press("bs1", 0, 1, 0, 4'd0);
    press("bs2", 0, 1, 0, 4'd0);
    press("bs3", 0, 1, 0, 4'd0);
    press("bs4", 0, 1, 0, 4'd0);

    press("pre5", 1, 0, 0, 4'd5);
    press("pre6", 1, 0, 0, 4'd6);
    press("combo", 1, 1, 1, 4'd3);

    press("pre9", 1, 0, 0, 4'd9);
    @(negedge clk);
    digit_in = 4'd8;
    enter_btn = 1;
    idle(8);
    @(negedge clk);
    reset_n = 0;
    @(posedge clk);
    #1;
    ent.delete();
    chk("midreset accept", accept, 0);
    chk("midreset reject", reject, 0);
    check_state("midreset");
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (accept || reject) seen = 1;
    end
    chk("held after reset quiet", seen, 0);
    release_btns("held after reset");
    press("repress8", 1, 0, 0, 4'd8);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      e = 0; b = 0; c = 0;
      if (r <= 5) e = 1;
      else if (r <= 7) b = 1;
      else if (r == 8) c = 1;
      else begin
        e = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        if (!(e || b || c)) e = 1;
      end
      press($sformatf("rand%0d", i), e, b, c, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
